// File: rtl/fft256_pkg.sv
// Shared constants for the 256-point radix-2^2 SDF FFT.
// Twiddles are kept in Q30 so any sample width can derive rounded values.
package fft256_pkg;

  localparam int N = 256;
  localparam int SPAN [4] = '{8, 4, 2, 1};

  localparam logic [63:0] COS1_Q30 = 64'd992008094;
  localparam logic [63:0] COS2_Q30 = 64'd759250125;
  localparam logic [63:0] SIN1_Q30 = 64'd410903207;

  function automatic logic [63:0] rnd_const(input int w);
    return 64'd1 << (w - 2);
  endfunction

  // round((2^(w-1)-1) * c) for a Q30 magnitude c
  function automatic logic signed [31:0] tw_amp(
    input int          w,
    input logic [63:0] c
  );
    return 32'((((64'd1 << (w - 1)) - 64'd1) * c
      + (64'd1 << 29)) >> 30);
  endfunction

  function automatic logic signed [31:0] tw16_re(
    input int         w,
    input logic [3:0] idx
  );
    logic signed [31:0] a, k1, k2, k3, r;
    a  = 32'((64'd1 << (w - 1)) - 64'd1);
    k1 = tw_amp(w, COS1_Q30);
    k2 = tw_amp(w, COS2_Q30);
    k3 = tw_amp(w, SIN1_Q30);
    r  = a;
    unique case (idx)
      4'd0:    r = a;
      4'd1:    r = k1;
      4'd2:    r = k2;
      4'd3:    r = k3;
      4'd4:    r = '0;
      4'd5:    r = -k3;
      4'd6:    r = -k2;
      4'd7:    r = -k1;
      4'd8:    r = -a;
      4'd9:    r = -k1;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic signed [31:0] tw16_im(
    input int         w,
    input logic [3:0] idx
  );
    logic signed [31:0] a, k1, k2, k3, r;
    a  = 32'((64'd1 << (w - 1)) - 64'd1);
    k1 = tw_amp(w, COS1_Q30);
    k2 = tw_amp(w, COS2_Q30);
    k3 = tw_amp(w, SIN1_Q30);
    r  = '0;
    unique case (idx)
      4'd0:    r = '0;
      4'd1:    r = -k3;
      4'd2:    r = -k2;
      4'd3:    r = -k1;
      4'd4:    r = -a;
      4'd5:    r = -k1;
      4'd6:    r = -k2;
      4'd7:    r = -k3;
      4'd8:    r = '0;
      4'd9:    r = k3;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fft256_tw16_rom.sv
// W16^idx coefficient lookup, idx 0..9, rounded to WIDTH bits.
module fft256_tw16_rom import fft256_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       addr,
  output logic [WIDTH-1:0] w_re,
  output logic [WIDTH-1:0] w_im
);

  always_comb begin
    w_re = WIDTH'(tw16_re(WIDTH, addr));
    w_im = WIDTH'(tw16_im(WIDTH, addr));
  end

endmodule

// File: rtl/fft256_stg6.sv
// Stage 6 of the 256-point SDF FFT: span-4 butterfly, then
// a two-register pipeline applying the W16 inter-stage twiddle.
module fft256_stg6 import fft256_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int DEPTH = SPAN[1];
  localparam int PW = 2 * WIDTH + 1;
  localparam logic [7:0] LAST = 8'(N - 1);
  localparam logic [7:0] START = 8'(DEPTH - 1);
  localparam logic signed [PW-1:0] RND = PW'(rnd_const(WIDTH));

  logic [7:0] di_count;
  logic [7:0] sp_count;
  logic       sp_en;
  logic       bf;
  logic       v1;

  logic [WIDTH-1:0] db_re [DEPTH];
  logic [WIDTH-1:0] db_im [DEPTH];
  logic [WIDTH-1:0] db_in_re, db_in_im;
  logic [WIDTH-1:0] sp_re, sp_im;
  logic signed [WIDTH:0] x0_re, x0_im, x1_re, x1_im;
  logic signed [WIDTH:0] s_re, s_im, d_re, d_im;

  logic [1:0]       sel;
  logic [3:0]       idx, idx1;
  logic [WIDTH-1:0] a_re, a_im;
  logic [WIDTH-1:0] w_re, w_im;
  logic signed [PW-1:0] ar, ai, wr, wi;
  logic signed [PW-1:0] m_re, m_im;

  assign bf = di_count[2];

  always_comb begin
    x0_re = {db_re[DEPTH-1][WIDTH-1], db_re[DEPTH-1]};
    x0_im = {db_im[DEPTH-1][WIDTH-1], db_im[DEPTH-1]};
    x1_re = {di_re[WIDTH-1], di_re};
    x1_im = {di_im[WIDTH-1], di_im};
    s_re  = x0_re + x1_re;
    s_im  = x0_im + x1_im;
    d_re  = x0_re - x1_re;
    d_im  = x0_im - x1_im;
    if (bf) begin
      sp_re    = WIDTH'(s_re >>> 1);
      sp_im    = WIDTH'(s_im >>> 1);
      db_in_re = WIDTH'(d_re >>> 1);
      db_in_im = WIDTH'(d_im >>> 1);
    end else begin
      sp_re    = db_re[DEPTH-1];
      sp_im    = db_im[DEPTH-1];
      db_in_re = di_re;
      db_in_im = di_im;
    end
  end

  always_ff @(posedge clock) begin
    db_re[0] <= db_in_re;
    db_im[0] <= db_in_im;
    for (int i = 1; i < DEPTH; i++) begin
      db_re[i] <= db_re[i-1];
      db_im[i] <= db_im[i-1];
    end
  end

  // a run ends after 256 outputs unless the next frame starts on that cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      di_count <= '0;
      sp_en    <= 1'b0;
      sp_count <= '0;
      v1       <= 1'b0;
      do_en    <= 1'b0;
    end else begin
      di_count <= di_en ? di_count + 8'd1 : 8'd0;
      sp_en    <= (di_count == START) ||
                  (sp_en && sp_count != LAST);
      sp_count <= sp_en ? sp_count + 8'd1 : 8'd0;
      v1       <= sp_en;
      do_en    <= v1;
    end
  end

  always_comb begin
    sel = {sp_count[2], sp_count[3]};
    idx = {2'b00, sel} * {2'b00, sp_count[1:0]};
  end

  always_ff @(posedge clock) begin
    a_re <= sp_re;
    a_im <= sp_im;
    idx1 <= idx;
  end

  fft256_tw16_rom #(.WIDTH(WIDTH)) u_rom (
    .addr (idx1),
    .w_re (w_re),
    .w_im (w_im)
  );

  always_comb begin
    ar   = {{(WIDTH+1){a_re[WIDTH-1]}}, a_re};
    ai   = {{(WIDTH+1){a_im[WIDTH-1]}}, a_im};
    wr   = {{(WIDTH+1){w_re[WIDTH-1]}}, w_re};
    wi   = {{(WIDTH+1){w_im[WIDTH-1]}}, w_im};
    m_re = ar * wr - ai * wi + RND;
    m_im = ar * wi + ai * wr + RND;
  end

  always_ff @(posedge clock) begin
    if (idx1 == 4'd0) begin
      do_re <= a_re;
      do_im <= a_im;
    end else begin
      do_re <= WIDTH'(m_re >>> (WIDTH - 1));
      do_im <= WIDTH'(m_im >>> (WIDTH - 1));
    end
  end

endmodule

// File: tb/tb_fft256_stg6.sv
// Directed bench for fft256_stg6: impulse, DC, twiddle sweep,
// back-to-back frames, mid-frame reset and an interrupted frame.
module tb_fft256_stg6;

  localparam int WIDTH = 16;
  localparam int MAXC = 1024;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             di_en = 1'b0;
  logic [WIDTH-1:0] di_re = '0;
  logic [WIDTH-1:0] di_im = '0;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;

  int errors = 0;
  int checks = 0;

  logic             in_en  [MAXC];
  logic [WIDTH-1:0] in_re  [MAXC];
  logic [WIDTH-1:0] in_im  [MAXC];
  logic             cap_en [MAXC];
  logic [WIDTH-1:0] cap_re [MAXC];
  logic [WIDTH-1:0] cap_im [MAXC];

  // outputs per sp_count mod 16, hand-computed
  int dc_re [16] = '{1000, 1000, 1000, 1000, 0, 0, 0, 0,
                     1000, 924, 707, 383, 0, 0, 0, 0};
  int dc_im [16] = '{0, 0, 0, 0, 0, 0, 0, 0,
                     0, -383, -707, -924, 0, 0, 0, 0};
  int sw_re [16] = '{0, 0, 0, 0, 0, 707, 1000, 707,
                     0, 383, 707, 924, 0, 924, 707, -383};
  int sw_im [16] = '{1000, 1000, 1000, 1000, 1000, 707, 0, -707,
                     1000, 924, 707, 383, 1000, 383, -707, -924};

  fft256_stg6 #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
    .do_im (do_im)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      in_en[i] = 1'b0;
      in_re[i] = '0;
      in_im[i] = '0;
    end
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clock);
      #1;
      di_en = in_en[t];
      di_re = in_re[t];
      di_im = in_im[t];
      @(negedge clock);
      cap_en[t] = do_en;
      cap_re[t] = do_re;
      cap_im[t] = do_im;
    end
    di_en = 1'b0;
  endtask

  function automatic int en_ones(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(cap_en[i]);
    return c;
  endfunction

  task automatic test_reset();
    int bad = 0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (do_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_en: do_en=%b required 0", do_en);
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (do_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_en: high %0d cycles required 0", bad);
    end
  endtask

  task automatic test_impulse(input string tag);
    int er;
    clear_stim();
    for (int t = 0; t < 256; t++) in_en[t] = 1'b1;
    in_re[0] = WIDTH'(16384);
    run(270);
    checks++;
    if (cap_en[5] !== 1'b0 || cap_en[6] !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: en@5=%b en@6=%b required 0 1",
               tag, cap_en[5], cap_en[6]);
    end
    checks++;
    if (en_ones(270) != 256 || cap_en[261] !== 1'b1 ||
        cap_en[262] !== 1'b0) begin
      errors++;
      $display("FAIL %s en_len: ones=%0d required 256 ending at 261",
               tag, en_ones(270));
    end
    for (int k = 0; k < 256; k++) begin
      er = (k == 0 || k == 4) ? 8192 : 0;
      checks++;
      if (cap_re[6+k] !== WIDTH'(er) || cap_im[6+k] !== '0) begin
        errors++;
        $display("FAIL %s out[%0d]: (%0d,%0d) required (%0d,0)", tag, k,
                 $signed(cap_re[6+k]), $signed(cap_im[6+k]), er);
      end
    end
  endtask

  task automatic test_dc();
    clear_stim();
    for (int t = 0; t < 256; t++) begin
      in_en[t] = 1'b1;
      in_re[t] = WIDTH'(1000);
    end
    run(270);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap_en[6+k] !== 1'b1 ||
          cap_re[6+k] !== WIDTH'(dc_re[k%16]) ||
          cap_im[6+k] !== WIDTH'(dc_im[k%16])) begin
        errors++;
        $display("FAIL dc out[%0d]: en=%b (%0d,%0d) required (%0d,%0d)",
                 k, cap_en[6+k], $signed(cap_re[6+k]),
                 $signed(cap_im[6+k]), dc_re[k%16], dc_im[k%16]);
      end
    end
  endtask

  task automatic test_twiddle_sweep();
    clear_stim();
    for (int t = 0; t < 256; t++) begin
      in_en[t] = 1'b1;
      in_im[t] = ((t % 8) < 4) ? WIDTH'(2000) : '0;
    end
    run(270);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap_re[6+k] !== WIDTH'(sw_re[k%16]) ||
          cap_im[6+k] !== WIDTH'(sw_im[k%16])) begin
        errors++;
        $display("FAIL sweep out[%0d]: (%0d,%0d) required (%0d,%0d)",
                 k, $signed(cap_re[6+k]), $signed(cap_im[6+k]),
                 sw_re[k%16], sw_im[k%16]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int er;
    clear_stim();
    for (int t = 0; t < 512; t++) begin
      in_en[t] = 1'b1;
      in_re[t] = (t < 256) ? WIDTH'(1000) : '0;
    end
    in_re[256] = WIDTH'(16384);
    run(530);
    checks++;
    if (en_ones(530) != 512 || cap_en[5] !== 1'b0 ||
        cap_en[6] !== 1'b1 || cap_en[517] !== 1'b1 ||
        cap_en[518] !== 1'b0) begin
      errors++;
      $display("FAIL b2b en_len: ones=%0d required 512 over 6..517",
               en_ones(530));
    end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap_re[6+k] !== WIDTH'(dc_re[k%16]) ||
          cap_im[6+k] !== WIDTH'(dc_im[k%16])) begin
        errors++;
        $display("FAIL b2b f1[%0d]: (%0d,%0d) required (%0d,%0d)",
                 k, $signed(cap_re[6+k]), $signed(cap_im[6+k]),
                 dc_re[k%16], dc_im[k%16]);
      end
    end
    for (int k = 0; k < 256; k++) begin
      er = (k == 0 || k == 4) ? 8192 : 0;
      checks++;
      if (cap_en[262+k] !== 1'b1 || cap_re[262+k] !== WIDTH'(er) ||
          cap_im[262+k] !== '0) begin
        errors++;
        $display("FAIL b2b f2[%0d]: en=%b (%0d,%0d) required (%0d,0)",
                 k, cap_en[262+k], $signed(cap_re[262+k]),
                 $signed(cap_im[262+k]), er);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    clear_stim();
    for (int t = 0; t < 256; t++) in_en[t] = 1'b1;
    in_re[0] = WIDTH'(16384);
    for (int t = 0; t < 107; t++) begin
      @(posedge clock);
      #1;
      di_en = in_en[t];
      di_re = in_re[t];
      di_im = in_im[t];
    end
    checks++;
    if (do_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_en: do_en=%b required 1", do_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (do_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_en: do_en=%b required 0", do_en);
    end
    di_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (do_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_idle: high %0d cycles required 0", bad);
    end
    test_impulse("after_reset");
  endtask

  task automatic test_abort();
    clear_stim();
    for (int t = 0; t < 256; t++) begin
      in_en[t] = !(t >= 50 && t <= 52);
      in_re[t] = WIDTH'(t * 37);
      in_im[t] = WIDTH'(-t * 11);
    end
    run(300);
    checks++;
    if (en_ones(300) != 256) begin
      errors++;
      $display("FAIL abort en_len: ones=%0d required 256", en_ones(300));
    end
    checks++;
    if (cap_en[5] !== 1'b0 || cap_en[6] !== 1'b1 ||
        cap_en[261] !== 1'b1 || cap_en[262] !== 1'b0) begin
      errors++;
      $display("FAIL abort en_edges: %b%b..%b%b required 01..10",
               cap_en[5], cap_en[6], cap_en[261], cap_en[262]);
    end
    test_impulse("after_abort");
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_dc();
    test_twiddle_sweep();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
